// File: rtl/fft_spec_pkg.sv
// fft_spec_pkg: shared types and sizing helpers for the spectrum accumulator
package fft_spec_pkg;
    typedef enum logic [1:0] {
        MODE_OVERWRITE = 2'd0,
        MODE_MAX       = 2'd1,
        MODE_AVG       = 2'd2
    } mode_e;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_READOUT
    } state_e;
    function automatic int addr_w(input int npoint);
        return $clog2(npoint / 2);
    endfunction
    function automatic int acc_w(input int mag_w, input int max_avg_log2);
        return mag_w + max_avg_log2;
    endfunction
    function automatic int navg_w(input int max_avg_log2);
        return $clog2(max_avg_log2 + 1);
    endfunction
    function automatic mode_e decode_mode(input logic [1:0] m);
        return (m == 2'd1) ? MODE_MAX : (m == 2'd2) ? MODE_AVG : MODE_OVERWRITE;
    endfunction
endpackage

// File: rtl/fft_acc_rmw.sv
// fft_acc_rmw: half-spectrum accumulator RAM with a two-stage read-modify-write combine path
module fft_acc_rmw import fft_spec_pkg::*; #(
    parameter int ADDR_W = 9,
    parameter int MAG_W  = 16,
    parameter int ACC_W  = 20
) (
    input  logic              sys_clk,
    input  logic              sys_rstn,
    input  logic              acc_valid,
    input  logic              acc_first,
    input  mode_e             acc_mode,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [MAG_W-1:0]  acc_mag,
    input  logic [ADDR_W-1:0] ro_addr,
    output logic [ACC_W-1:0]  rd_data,
    output logic              busy
);
    logic [ACC_W-1:0]  mem [2**ADDR_W];
    logic [ACC_W-1:0]  rd_data_q, wr_data, mag_ext;
    logic [ADDR_W-1:0] rd_addr, addr_q, addr_d;
    logic [MAG_W-1:0]  mag_q, mag_d;
    logic              v_q, v_d, first_q, first_d;
    mode_e             mode_q, mode_d;

    // Stage the beat for one cycle while the old bin value is read; the first frame just overwrites
    always_comb begin
        v_d     = acc_valid;
        first_d = acc_first;
        mode_d  = acc_mode;
        addr_d  = acc_addr;
        mag_d   = acc_mag;
        mag_ext = ACC_W'(mag_q);
        wr_data = (first_q || mode_q == MODE_OVERWRITE) ? mag_ext :
                  (mode_q == MODE_MAX) ? ((rd_data_q > mag_ext) ? rd_data_q : mag_ext) :
                  rd_data_q + mag_ext;
        rd_addr = acc_valid ? acc_addr : ro_addr;
    end

    // Pipeline stage register
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            v_q     <= 1'b0;
            first_q <= 1'b0;
            mode_q  <= MODE_OVERWRITE;
            addr_q  <= '0;
            mag_q   <= '0;
        end else begin
            v_q     <= v_d;
            first_q <= first_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            mag_q   <= mag_d;
        end
    end

    // 1R1W RAM, registered read (old data when read and write hit the same address)
    always_ff @(posedge sys_clk) begin
        if (v_q) mem[addr_q] <= wr_data;
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;
    assign busy    = v_q;
endmodule

// File: rtl/fft_spec_accum.sv
// fft_spec_accum: frame-aware half-spectrum accumulator (overwrite/max/avg) with AXI-S readout
// Optional PEAK_DETECT_EN adds peak_valid/peak_bin/peak_mag reporting the strongest non-DC bin.
module fft_spec_accum import fft_spec_pkg::*; #(
    parameter int NPOINT       = 1024,
    parameter int MAG_W        = 16,
    parameter int MAX_AVG_LOG2 = 4
) (
    input  logic                            sys_clk,
    input  logic                            sys_rstn,
    input  logic [1:0]                      cfg_mode,
    input  logic [navg_w(MAX_AVG_LOG2)-1:0] cfg_navg_log2,
    input  logic                            mag_tvalid,
    input  logic                            mag_tlast,
    input  logic [MAG_W-1:0]                mag_tdata,
    output logic                            out_tvalid,
    input  logic                            out_tready,
    output logic [MAG_W-1:0]                out_tdata,
    output logic [addr_w(NPOINT)-1:0]       out_bin,
    output logic                            out_tlast,
    output logic                            err_frame,
    output logic [15:0]                     drop_cnt
`ifdef PEAK_DETECT_EN
    ,
    output logic                            peak_valid,
    output logic [addr_w(NPOINT)-1:0]       peak_bin,
    output logic [MAG_W-1:0]                peak_mag
`endif
);
    localparam int HALF   = NPOINT / 2;
    localparam int ADDR_W = addr_w(NPOINT);
    localparam int ACC_W  = acc_w(MAG_W, MAX_AVG_LOG2);
    localparam int NAV_W  = navg_w(MAX_AVG_LOG2);
    localparam int BIN_W  = $clog2(NPOINT);
    localparam int FC_W   = MAX_AVG_LOG2 + 1;

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [BIN_W-1:0]  bin_q, bin_d;
    logic [NAV_W-1:0]  navg_q, navg_d, cfg_n, nsel;
    logic [FC_W-1:0]   fc_q, fc_d, fc_last;
    logic [15:0]       drop_q, drop_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   ra_q, ra_d;
    logic [ADDR_W-1:0] pb_q, pb_d, ob_q, ob_d, sb_q, sb_d;
    logic [MAG_W-1:0]  od_q, od_d, sd_q, sd_d, rd_mag;
    logic              p_q, p_d, ov_q, ov_d, sv_q, sv_d;
    logic              frame_start, frame_end, bin_last, pop, issue, acc_valid, acc_first, rmw_busy;
    logic [ACC_W-1:0]  rmw_rd;

    assign bin_last    = bin_q == BIN_W'(NPOINT - 1);
    assign frame_start = mag_tvalid && bin_q == '0;
    assign frame_end   = mag_tvalid && (mag_tlast || bin_last);
    assign cfg_n       = (cfg_navg_log2 > NAV_W'(MAX_AVG_LOG2)) ? NAV_W'(MAX_AVG_LOG2) : cfg_navg_log2;
    assign nsel        = (state_q == ST_IDLE) ? cfg_n : navg_q;
    assign fc_last     = ~({FC_W{1'b1}} << nsel);
    assign acc_valid   = mag_tvalid && !bin_q[BIN_W-1] &&
                         (state_q == ST_ACCUM || (state_q == ST_IDLE && bin_q == '0));
    assign acc_first   = state_q == ST_IDLE || fc_q == '0;
    assign pop         = ov_q && out_tready;

    fft_acc_rmw #(.ADDR_W(ADDR_W), .MAG_W(MAG_W), .ACC_W(ACC_W)) u_rmw (
        .sys_clk  (sys_clk),
        .sys_rstn (sys_rstn),
        .acc_valid(acc_valid),
        .acc_first(acc_first),
        .acc_mode (mode_q),
        .acc_addr (bin_q[ADDR_W-1:0]),
        .acc_mag  (mag_tdata),
        .ro_addr  (ra_q[ADDR_W-1:0]),
        .rd_data  (rmw_rd),
        .busy     (rmw_busy)
    );

    // Frame tracking, drop/error bookkeeping and interval state machine
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        navg_d  = navg_q;
        fc_d    = fc_q;
        bin_d   = bin_q;
        err_d   = err_q;
        drop_d  = drop_q;
        if (mag_tvalid) begin
            bin_d = frame_end ? '0 : bin_q + BIN_W'(1);
            err_d = err_q || (mag_tlast != bin_last);
        end
        if (frame_start && (state_q == ST_DRAIN || state_q == ST_READOUT) && drop_q != 16'hFFFF)
            drop_d = drop_q + 16'd1;
        case (state_q)
            ST_IDLE: if (frame_start) begin
                mode_d  = decode_mode(cfg_mode);
                navg_d  = cfg_n;
                fc_d    = FC_W'(frame_end);
                state_d = (frame_end && fc_last == '0) ? ST_DRAIN : ST_ACCUM;
            end
            ST_ACCUM: if (frame_end) begin
                fc_d = fc_q + FC_W'(1);
                if (fc_q == fc_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: if (!rmw_busy) state_d = ST_READOUT;
            default: if (pop && out_tlast) state_d = ST_IDLE;
        endcase
    end

    // Readout: RAM reads land in the output register or, when it is stalled, in a one-entry skid
    always_comb begin
        rd_mag = (mode_q == MODE_AVG) ? MAG_W'(rmw_rd >> navg_q) : rmw_rd[MAG_W-1:0];
        issue  = state_q == ST_READOUT && !ra_q[ADDR_W] &&
                 (2'(ov_q) + 2'(sv_q) + 2'(p_q) - 2'(pop) <= 2'd1);
        ra_d   = (state_q == ST_DRAIN) ? '0 : ra_q + (ADDR_W + 1)'(issue);
        p_d    = issue;
        pb_d   = ra_q[ADDR_W-1:0];
        ov_d   = ov_q;
        od_d   = od_q;
        ob_d   = ob_q;
        sv_d   = sv_q;
        sd_d   = sd_q;
        sb_d   = sb_q;
        if (!ov_q || pop) begin
            ov_d = sv_q || p_q;
            od_d = sv_q ? sd_q : p_q ? rd_mag : od_q;
            ob_d = sv_q ? sb_q : p_q ? pb_q : ob_q;
            sv_d = sv_q && p_q;
            sd_d = (sv_q && p_q) ? rd_mag : sd_q;
            sb_d = (sv_q && p_q) ? pb_q : sb_q;
        end else if (p_q) begin
            sv_d = 1'b1;
            sd_d = rd_mag;
            sb_d = pb_q;
        end
    end

    // Control and readout registers
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_OVERWRITE;
            navg_q  <= '0;
            fc_q    <= '0;
            bin_q   <= '0;
            err_q   <= 1'b0;
            drop_q  <= '0;
            ra_q    <= '0;
            p_q     <= 1'b0;
            pb_q    <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            ob_q    <= '0;
            sv_q    <= 1'b0;
            sd_q    <= '0;
            sb_q    <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            navg_q  <= navg_d;
            fc_q    <= fc_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
            ra_q    <= ra_d;
            p_q     <= p_d;
            pb_q    <= pb_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            ob_q    <= ob_d;
            sv_q    <= sv_d;
            sd_q    <= sd_d;
            sb_q    <= sb_d;
        end
    end

    assign out_tvalid = ov_q;
    assign out_tdata  = od_q;
    assign out_bin    = ob_q;
    assign out_tlast  = ov_q && ob_q == ADDR_W'(HALF - 1);
    assign err_frame  = err_q;
    assign drop_cnt   = drop_q;

`ifdef PEAK_DETECT_EN
    logic [MAG_W-1:0]  rm_q, rm_d, pk_m_q, pk_m_d, nm;
    logic [ADDR_W-1:0] rb_q, rb_d, pk_b_q, pk_b_d, nb;
    logic              pk_v_q, pk_v_d, cand;

    // Running max over transferred non-DC beats; strict compare keeps the lowest bin on ties
    always_comb begin
        cand   = pop && ob_q != '0 && od_q > rm_q;
        nm     = cand ? od_q : rm_q;
        nb     = cand ? ob_q : rb_q;
        rm_d   = (state_q == ST_DRAIN) ? '0 : pop ? nm : rm_q;
        rb_d   = (state_q == ST_DRAIN) ? '0 : pop ? nb : rb_q;
        pk_v_d = pop && out_tlast;
        pk_m_d = pk_v_d ? nm : pk_m_q;
        pk_b_d = pk_v_d ? nb : pk_b_q;
    end

    // Peak tracking registers
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            rm_q   <= '0;
            rb_q   <= '0;
            pk_v_q <= 1'b0;
            pk_m_q <= '0;
            pk_b_q <= '0;
        end else begin
            rm_q   <= rm_d;
            rb_q   <= rb_d;
            pk_v_q <= pk_v_d;
            pk_m_q <= pk_m_d;
            pk_b_q <= pk_b_d;
        end
    end

    assign peak_valid = pk_v_q;
    assign peak_bin   = pk_b_q;
    assign peak_mag   = pk_m_q;
`endif
endmodule
